// File: rtl/keypad_event_ctrl.sv
// 4x4 keypad front end: periodic sampling, debounce, press-edge detection and a
// 4-deep event FIFO of key codes with sticky overflow.
module keypad_event_ctrl #(
    parameter int SAMPLE_DIV       = 2000004,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keyState,
    input  logic        keyReady,
    input  logic        clrOverflow,
    output logic        keyValid,
    output logic [3:0]  keyCode,
    output logic [2:0]  fifoCount,
    output logic        overflow,
    output logic        anyKeyHeld
);
    // state | meaning
    // IDLE  | no pending press events
    // DRAIN | pushing lowest pending key index into the FIFO, one per cycle

    localparam int            CW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [3:0]    DEB_MIN  = 4'(DEBOUNCE_SAMPLES);

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [CW-1:0] sample_cnt;
    logic          tick;
    logic [3:0]    stable_cnt, stable_nxt;
    logic [15:0]   last_sample, debounced, pending, pending_nxt, rise;
    logic          deb_load;
    state_t        state, state_nxt;
    logic          push;
    logic [3:0]    push_code;
    logic [15:0]   push_mask;
    logic [3:0]    mem [4];
    logic [1:0]    rd_ptr, wr_ptr, rd_nxt;
    logic [2:0]    count_nxt;
    logic [3:0]    head_nxt;
    logic          pop, push_ok, drop;

    assign tick       = (sample_cnt == DIV_LAST);
    assign stable_nxt = (keyState != last_sample) ? 4'd1 :
                        (stable_cnt == 4'd15)     ? 4'd15 : stable_cnt + 4'd1;
    assign deb_load   = (stable_cnt >= DEB_MIN) && (last_sample != debounced);
    assign rise       = deb_load ? (last_sample & ~debounced) : 16'h0000;
    assign anyKeyHeld = |debounced;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt  <= '0;
            stable_cnt  <= '0;
            last_sample <= '0;
            debounced   <= '0;
            pending     <= '0;
        end else begin
            sample_cnt <= tick ? '0 : sample_cnt + CW'(1);
            if (tick) begin
                last_sample <= keyState;
                stable_cnt  <= stable_nxt;
            end
            if (deb_load) debounced <= last_sample;
            pending <= pending_nxt;
        end
    end

    // Lowest set bit wins so simultaneous presses drain in ascending key order.
    always_comb begin
        push_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) push_code = 4'(i);
        end
    end

    assign push_mask   = push ? (16'h0001 << push_code) : 16'h0000;
    assign pending_nxt = (pending & ~push_mask) | rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending != 16'h0000)     state_nxt = DRAIN;
            DRAIN:   if (pending_nxt == 16'h0000) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push = (state == DRAIN);
    end

    assign pop     = (fifoCount != 3'd0) && keyReady;
    assign push_ok = push && ((fifoCount != 3'd4) || pop);
    assign drop    = push && !push_ok;
    assign rd_nxt  = rd_ptr + {1'b0, pop};

    always_comb begin
        count_nxt = fifoCount;
        if (push_ok && !pop)      count_nxt = fifoCount + 3'd1;
        else if (!push_ok && pop) count_nxt = fifoCount - 3'd1;
    end

    // New head may be the entry being written this very cycle.
    assign head_nxt = (push_ok && (wr_ptr == rd_nxt)) ? push_code : mem[rd_nxt];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifoCount <= '0;
            keyValid  <= 1'b0;
            keyCode   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            rd_ptr    <= rd_nxt;
            fifoCount <= count_nxt;
            keyValid  <= (count_nxt != 3'd0);
            keyCode   <= (count_nxt != 3'd0) ? head_nxt : 4'd0;
            if (drop)             overflow <= 1'b1;
            else if (clrOverflow) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Bench for keypad_event_ctrl: vector table of key patterns plus hand-written
// sequences for latency, bounce rejection, overflow, full-FIFO push/pop and reset.
module tb_keypad_event_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keyState = '0;
    logic        keyReady = 1'b0;
    logic        clrOverflow = 1'b0;
    logic        keyValid;
    logic [3:0]  keyCode;
    logic [2:0]  fifoCount;
    logic        overflow;
    logic        anyKeyHeld;

    keypad_event_ctrl #(.SAMPLE_DIV(4), .DEBOUNCE_SAMPLES(3)) dut (
        .clk(clk), .rst(rst), .keyState(keyState), .keyReady(keyReady),
        .clrOverflow(clrOverflow), .keyValid(keyValid), .keyCode(keyCode),
        .fifoCount(fifoCount), .overflow(overflow), .anyKeyHeld(anyKeyHeld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] keys;
        int          hold;
        logic        held;
    } vec_t;

    vec_t        vt [7];
    logic [3:0]  exp_q [$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [15:0] prev;
    int          lat;
    logic        saw_valid, saw_held;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, keyValid, 0);
        check({tag, "_code"}, keyCode, 0);
        check({tag, "_count"}, fifoCount, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_held"}, anyKeyHeld, 0);
    endtask

    task automatic do_reset(input logic [15:0] keys);
        @(posedge clk); #1;
        rst = 1'b0;
        keyState = keys;
        keyReady = 1'b0;
        clrOverflow = 1'b0;
        exp_q.delete();
        cycles(2);
        check_zero_outputs("reset");
        rst = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || keyValid) && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_held(input string name, input int budget);
        int i = 0;
        while (!anyKeyHeld && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check(name, anyKeyHeld, 1);
    endtask

    // Scoreboard: pops sampled mid-cycle, the pop itself lands on the next edge.
    always @(negedge clk) begin
        if (rst) begin
            if (keyValid && keyReady) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_pop: got code %0d, want no event", keyCode);
                end else begin
                    check("pop_code", keyCode, exp_q.pop_front());
                end
            end else if (!keyValid) begin
                check("idle_code", keyCode, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{keys: 16'h0020, hold: 48, held: 1'b1};
        vt[1] = '{keys: 16'h0000, hold: 48, held: 1'b0};
        vt[2] = '{keys: 16'h8401, hold: 48, held: 1'b1};
        vt[3] = '{keys: 16'h8400, hold: 48, held: 1'b1};
        vt[4] = '{keys: 16'h8402, hold: 48, held: 1'b1};
        vt[5] = '{keys: 16'hFFFF, hold: 64, held: 1'b1};
        vt[6] = '{keys: 16'h0000, hold: 48, held: 1'b0};

        // Table: consumer always ready; events are rising bits in ascending order.
        do_reset(16'h0000);
        prev = '0;
        keyReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            keyState = vt[i].keys;
            for (int b = 0; b < 16; b++)
                if (vt[i].keys[b] && !prev[b]) exp_q.push_back(4'(b));
            prev = vt[i].keys;
            cycles(vt[i].hold);
            check($sformatf("vec%0d_held", i), anyKeyHeld, vt[i].held);
            check($sformatf("vec%0d_count", i), fifoCount, 0);
            check($sformatf("vec%0d_ovf", i), overflow, 0);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
        end

        // First event latency: 3 ticks (edges 4,8,12), debounce 13, DRAIN 14, push 15.
        do_reset(16'h0020);
        lat = 0;
        while (!keyValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("first_latency", lat, 15);
        check("first_code", keyCode, 5);
        check("first_count", fifoCount, 1);
        cycles(40);
        check("held_no_repeat", fifoCount, 1);
        exp_q.push_back(4'd5);
        keyReady = 1'b1;
        wait_drain("first_drain", 20);

        // Bounce: value flips every 4 cycles, so every tick sees a change.
        do_reset(16'h0000);
        keyReady = 1'b1;
        saw_valid = 1'b0;
        saw_held = 1'b0;
        for (int t = 0; t < 10; t++) begin
            keyState = (t % 2 == 0) ? 16'h0001 : 16'h0000;
            for (int c = 0; c < 4; c++) begin
                cycles(1);
                saw_valid |= keyValid;
                saw_held |= anyKeyHeld;
            end
        end
        cycles(20);
        check("bounce_valid", saw_valid, 0);
        check("bounce_held", saw_held, 0);

        // Overflow: six presses, no consumer.
        do_reset(16'h0000);
        keyState = 16'h003F;
        cycles(48);
        check("ovf_count", fifoCount, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", keyCode, 0);
        clrOverflow = 1'b1;
        cycles(1);
        clrOverflow = 1'b0;
        check("ovf_clear", overflow, 0);
        keyState = 16'h0000;
        cycles(24);
        check("release_held", anyKeyHeld, 0);
        check("release_count", fifoCount, 4);

        // Full FIFO: pop exactly in the single DRAIN push cycle.
        keyState = 16'h0100;
        wait_held("full_press_seen", 30);
        @(posedge clk); #1;
        keyReady = 1'b1;
        exp_q.push_back(4'd0);
        @(posedge clk); #1;
        keyReady = 1'b0;
        check("full_pp_count", fifoCount, 4);
        check("full_pp_ovf", overflow, 0);
        check("full_pp_head", keyCode, 1);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd8);
        keyReady = 1'b1;
        wait_drain("full_tail_drain", 20);
        check("full_end_ovf", overflow, 0);

        // Reset while draining three pending presses.
        do_reset(16'h0000);
        keyState = 16'h8401;
        wait_held("rst_press_seen", 30);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_zero_outputs("mid_drain_rst");
        exp_q.delete();
        cycles(2);
        rst = 1'b1;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd10);
        exp_q.push_back(4'd15);
        keyReady = 1'b1;
        wait_drain("rst_reissue", 60);
        cycles(20);
        check("rst_reissue_count", fifoCount, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/keypad_event_ctrl.md
KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

Interface
REQ-001 Parameter SAMPLE_DIV, default 2000004: clk cycles between debounce samples, one full 4-row scan.
REQ-002 Parameter DEBOUNCE_SAMPLES, default 3: consecutive identical samples needed to accept a new key vector; legal range 1..15.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 keyState  input  16  raw key matrix, bit 4*row+col, 1 = pressed; may change on any cycle.
REQ-006 keyReady  input  1  consumer accepts head entry this cycle.
REQ-007 clrOverflow  input  1  synchronous clear of overflow flag.
REQ-008 keyValid  output  1  FIFO non-empty.
REQ-009 keyCode  output  4  head-of-FIFO key index (0..15); 0 when keyValid=0.
REQ-010 fifoCount  output  3  entries held, 0..4.
REQ-011 overflow  output  1  sticky: a press event was dropped.
REQ-012 anyKeyHeld  output  1  OR of debounced key vector.

Function
REQ-013 Sample counter SHALL count 0..SAMPLE_DIV-1 and wrap; a sample tick SHALL occur in the cycle the counter equals SAMPLE_DIV-1.
REQ-014 On each tick: if keyState equals lastSample, stableCnt SHALL increment, saturating at 15; otherwise stableCnt SHALL load 1. lastSample SHALL load keyState.
REQ-015 When the post-update stableCnt >= DEBOUNCE_SAMPLES and lastSample differs from debounced, debounced SHALL load lastSample one cycle after the tick.
REQ-016 On a debounced update, pending SHALL OR in (new debounced & ~old debounced): rising edges only. Releases SHALL produce no event.
REQ-017 Enqueue FSM states: IDLE and DRAIN.
- IDLE -> DRAIN when pending != 0.
- In DRAIN, push the lowest set bit index of pending, clear that bit; one push per cycle.
- DRAIN -> IDLE in the cycle pending becomes 0.
REQ-018 FIFO SHALL be 4 entries x 4 bits, circular, with 2-bit read/write pointers that wrap 3 -> 0.
REQ-019 Pop SHALL occur when keyValid=1 and keyReady=1; keyReady while empty SHALL be ignored.
REQ-020 Push when full with no pop in the same cycle SHALL drop the code and set overflow; the pending bit is still cleared.
REQ-021 Simultaneous push and pop while full SHALL both succeed, with fifoCount staying 4.
REQ-022 Simultaneous push and pop while empty: the push SHALL succeed, the pop is ignored, and fifoCount becomes 1.
REQ-023 Setting overflow SHALL take priority over clrOverflow in the same cycle.
REQ-024 keyValid, keyCode and fifoCount SHALL be registered, and SHALL reflect the FIFO state after the edge with no combinational input-to-output path.
REQ-025 A new press arriving during DRAIN SHALL merge into pending and never be lost unless dropped per REQ-020.

Reset
REQ-026 rst=0 SHALL asynchronously clear the sample counter, stableCnt, lastSample, debounced, pending, pointers, FIFO contents, overflow and the FSM (to IDLE).
REQ-027 During reset, all outputs SHALL be 0.
REQ-028 Reset mid-DRAIN SHALL discard pending events; after release, keys already held SHALL re-debounce from zero and generate fresh press events.

Verification (SAMPLE_DIV=4, DEBOUNCE_SAMPLES=3)
REQ-029 Hold keyState=16'h0020 from reset release -> keyValid=1 with keyCode=5 and fifoCount=1 after the third tick plus pipeline, with no further events while held.
REQ-030 Toggle keyState between 16'h0001 and 0 on every tick for 10 ticks -> no event and anyKeyHeld=0.
REQ-031 Change keyState 0 -> 16'h8401 within one stable window, keyReady=1 -> codes 0, 10, 15 pop in that order on consecutive cycles.
REQ-032 keyReady=0 with 6 distinct presses -> fifoCount=4, FIFO holds the first 4 codes, overflow=1; pulse clrOverflow -> overflow=0.
REQ-033 FIFO full while a push and keyReady=1 coincide -> fifoCount stays 4, the oldest code leaves, and the new code sits at the tail.
REQ-034 Assert rst during DRAIN with 3 bits pending -> all outputs 0 immediately; keyState held -> 3 events re-issued after 3 ticks.
